xor_stale_output_monitor: RTL and testbench

- Sequential checker placed directly downstream of the combinational XOR stage (C = A ^ B).
- On every accepted cycle, compares the stage's output `c` against the golden `a ^ b`. This catches stale outputs caused by an incomplete sensitivity list or similar bugs.
- Groups samples into frames of FRAME_LEN, then reports per frame: error count, index of the first error, and parity of `c`.
- The frame report goes out over a valid/ready handshake to the lab scoreboard.

---
 rtl/xor_mon_pkg.sv | 14 +
 rtl/xor_mon_frame_acc.sv | 69 ++++++
 rtl/xor_stale_output_monitor.sv | 128 ++++++++++++
 tb/tb_xor_stale_output_monitor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_mon_pkg.sv
// Shared types and helpers for the XOR stale-output monitor.
// Optional sticky error flag is enabled by defining XOR_MON_STICKY_ERR_EN.
package xor_mon_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } mon_state_t;

    function automatic int calc_cnt_w(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xor_mon_frame_acc.sv
// Per-frame accumulators: sample count, error count, first error index, parity.
// The *_d outputs are frame totals including the sample accepted this cycle.
module xor_mon_frame_acc
    import xor_mon_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             mism_i,
    input  logic             c_i,
    output logic             last_o,
    output logic [CNT_W-1:0] err_cnt_d_o,
    output logic [IDX_W-1:0] first_idx_d_o,
    output logic             parity_d_o
);

    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic             parity_q, parity_d;

    assign last_o = (smp_cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        smp_cnt_d   = smp_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        parity_d    = parity_q;
        if (accept_i) begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
            parity_d  = parity_q ^ c_i;
            if (mism_i) begin
                if (err_cnt_q != CNT_W'(FRAME_LEN))
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                if (err_cnt_q == '0)
                    first_idx_d = smp_cnt_q[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            parity_q    <= 1'b0;
        end else if (clear_i) begin
            smp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            parity_q    <= 1'b0;
        end else begin
            smp_cnt_q   <= smp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            parity_q    <= parity_d;
        end
    end

    assign err_cnt_d_o   = err_cnt_d;
    assign first_idx_d_o = first_idx_d;
    assign parity_d_o    = parity_d;

endmodule

// File: rtl/xor_stale_output_monitor.sv
// Checks c == a ^ b per accepted sample and reports per-frame summaries.
// Sticky error flag is compiled in only with XOR_MON_STICKY_ERR_EN.
module xor_stale_output_monitor
    import xor_mon_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    localparam int CNT_W    = calc_cnt_w(FRAME_LEN),
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_err_cnt,
    output logic [IDX_W-1:0] out_first_idx,
    output logic             out_parity,
    output logic             out_err,
    output logic             err_pulse,
    output logic             sticky_err,
    input  logic             clear_sticky
);

    mon_state_t       state_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] out_err_cnt_q;
    logic [IDX_W-1:0] out_first_idx_q;
    logic             out_parity_q;
    logic             out_err_q;
    logic             err_pulse_q;

    logic             accept;
    logic             mism;
    logic             last;
    logic             acc_clear;
    logic [CNT_W-1:0] err_cnt_d;
    logic [IDX_W-1:0] first_idx_d;
    logic             parity_d;

    assign in_ready  = (state_q == ACCUM);
    // flush takes priority over a sample presented in the same cycle
    assign accept    = in_valid && in_ready && !flush;
    assign mism      = c ^ (a ^ b);
    assign acc_clear = (in_ready && flush) || (accept && last);

    xor_mon_frame_acc #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_acc (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (acc_clear),
        .accept_i      (accept),
        .mism_i        (mism),
        .c_i           (c),
        .last_o        (last),
        .err_cnt_d_o   (err_cnt_d),
        .first_idx_d_o (first_idx_d),
        .parity_d_o    (parity_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ACCUM;
            out_valid_q     <= 1'b0;
            out_err_cnt_q   <= '0;
            out_first_idx_q <= '0;
            out_parity_q    <= 1'b0;
            out_err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept && last) begin
                        out_err_cnt_q   <= err_cnt_d;
                        out_first_idx_q <= first_idx_d;
                        out_parity_q    <= parity_d;
                        out_err_q       <= (err_cnt_d != '0);
                        out_valid_q     <= 1'b1;
                        state_q         <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_pulse_q <= 1'b0;
        else     err_pulse_q <= accept && mism;
    end

`ifdef XOR_MON_STICKY_ERR_EN
    logic sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  sticky_q <= 1'b0;
        else if (accept && mism)  sticky_q <= 1'b1;
        else if (clear_sticky)    sticky_q <= 1'b0;
    end

    assign sticky_err = sticky_q;
`else
    logic unused_clear_sticky;

    assign unused_clear_sticky = clear_sticky;
    assign sticky_err          = 1'b0;
`endif

    assign out_valid     = out_valid_q;
    assign out_err_cnt   = out_err_cnt_q;
    assign out_first_idx = out_first_idx_q;
    assign out_parity    = out_parity_q;
    assign out_err       = out_err_q;
    assign err_pulse     = err_pulse_q;

endmodule

// File: tb/tb_xor_stale_output_monitor.sv
// Table-driven frames, hand sequences and a randomized run against a queue model.
module tb_xor_stale_output_monitor;

    localparam int FL = 8;
`ifdef XOR_MON_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_err_cnt;
    logic [2:0] out_first_idx;
    logic       out_parity;
    logic       out_err;
    logic       err_pulse;
    logic       sticky_err;
    logic       clear_sticky = 1'b0;

    int total = 0;
    int bad   = 0;

    xor_stale_output_monitor #(.FRAME_LEN(FL)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .c             (c),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_err_cnt   (out_err_cnt),
        .out_first_idx (out_first_idx),
        .out_parity    (out_parity),
        .out_err       (out_err),
        .err_pulse     (err_pulse),
        .sticky_err    (sticky_err),
        .clear_sticky  (clear_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] flip;
        int         cnt;
        int         idx;
        int         par;
    } frame_vec_t;

    frame_vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        clear_sticky = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [7:0] fa,
                             input logic [7:0] fb, input logic [7:0] ff);
        for (int i = 0; i < FL; i++) begin
            chk({nm, "_in_ready"}, in_ready, 1);
            in_valid = 1'b1;
            a = fa[i];
            b = fb[i];
            c = fa[i] ^ fb[i] ^ ff[i];
            cyc();
            chk({nm, "_pulse"}, err_pulse, ff[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_report(input string nm, input int cnt,
                              input int idx, input int par);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_in_ready_hold"}, in_ready, 0);
        chk({nm, "_err_cnt"}, out_err_cnt, cnt);
        chk({nm, "_first_idx"}, out_first_idx, idx);
        chk({nm, "_parity"}, out_parity, par);
        chk({nm, "_out_err"}, out_err, int'(cnt != 0));
    endtask

    bit q_m[$];
    bit q_c[$];
    bit m_hold;
    int m_cnt;
    int m_idx;
    int m_par;
    bit m_pulse;
    bit m_sticky;

    initial begin
        tbl[0] = '{"clean",   8'hCC, 8'hAA, 8'h00, 0, 0, 0};
        tbl[1] = '{"stale",   8'hFF, 8'hFF, 8'h48, 2, 3, 0};
        tbl[2] = '{"first0",  8'h00, 8'h00, 8'h01, 1, 0, 1};
        tbl[3] = '{"all_bad", 8'h0F, 8'h00, 8'hFF, 8, 0, 0};
        tbl[4] = '{"last7",   8'h00, 8'h00, 8'h80, 1, 7, 1};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_cnt", out_err_cnt, 0);
        chk("rst_first_idx", out_first_idx, 0);
        chk("rst_parity", out_parity, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_sticky", sticky_err, 0);

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t].name, tbl[t].va, tbl[t].vb, tbl[t].flip);
            chk_report(tbl[t].name, tbl[t].cnt, tbl[t].idx, tbl[t].par);
            cyc();
            chk({tbl[t].name, "_released"}, out_valid, 0);
            chk({tbl[t].name, "_in_ready_back"}, in_ready, 1);
        end

        // backpressure: mismatching samples offered in HOLD must be ignored
        do_reset();
        out_ready = 1'b0;
        run_frame("bp", 8'hFF, 8'hFF, 8'h48);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 1'b1;
            b = 1'b0;
            c = 1'b0;
            cyc();
            chk_report("bp_hold", 2, 3, 0);
            chk("bp_hold_pulse", err_pulse, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        run_frame("bp_next", 8'hCC, 8'hAA, 8'h00);
        chk_report("bp_next", 0, 0, 0);
        cyc();

        // flush with a sample in the same cycle drops the sample
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 1'b0;
            b = 1'b0;
            c = (i == 1 || i == 2);
            cyc();
        end
        flush = 1'b1;
        c = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_pulse", err_pulse, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_no_report", out_valid, 0);
        run_frame("post_flush", 8'h5A, 8'h3C, 8'h00);
        chk_report("post_flush", 0, 0, 0);
        cyc();

        // asynchronous reset while holding a report
        out_ready = 1'b0;
        run_frame("rst_hold", 8'h00, 8'h00, 8'h01);
        chk("rst_hold_valid_pre", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_ready", in_ready, 1);
        chk("rst_hold_cnt", out_err_cnt, 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_hold_no_stale", out_valid, 0);
        end

        // sticky flag behaviour
        do_reset();
        run_frame("stk_err", 8'h00, 8'h00, 8'h04);
        chk("stk_set", sticky_err, int'(STICKY));
        cyc();
        run_frame("stk_clean", 8'hCC, 8'hAA, 8'h00);
        cyc();
        chk("stk_persist", sticky_err, int'(STICKY));
        clear_sticky = 1'b1;
        cyc();
        clear_sticky = 1'b0;
        chk("stk_cleared", sticky_err, 0);
        in_valid = 1'b1;
        a = 1'b1;
        b = 1'b1;
        c = 1'b1;
        clear_sticky = 1'b1;
        cyc();
        clear_sticky = 1'b0;
        in_valid = 1'b0;
        chk("stk_set_wins", sticky_err, int'(STICKY));

        // randomized run against the queue-based frame model
        do_reset();
        q_m.delete();
        q_c.delete();
        m_hold = 0;
        m_cnt = 0;
        m_idx = 0;
        m_par = 0;
        m_sticky = 0;
        for (int n = 0; n < 3000; n++) begin
            bit iv, aa, bb, cc, fl, ordy, cs;
            iv   = ($urandom_range(0, 3) != 0);
            aa   = 1'($urandom_range(0, 1));
            bb   = 1'($urandom_range(0, 1));
            cc   = aa ^ bb ^ ($urandom_range(0, 5) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            cs   = ($urandom_range(0, 29) == 0);
            in_valid = iv;
            a = aa;
            b = bb;
            c = cc;
            flush = fl;
            out_ready = ordy;
            clear_sticky = cs;
            #1;
            chk("rnd_in_ready", in_ready, int'(!m_hold));

            m_pulse = 0;
            if (m_hold) begin
                if (ordy) m_hold = 0;
            end else if (fl) begin
                q_m.delete();
                q_c.delete();
            end else if (iv) begin
                q_m.push_back(aa ^ bb ^ cc);
                q_c.push_back(cc);
                m_pulse = aa ^ bb ^ cc;
                if (q_m.size() == FL) begin
                    m_cnt = 0;
                    m_idx = -1;
                    m_par = 0;
                    for (int k = 0; k < FL; k++) begin
                        m_cnt += q_m[k];
                        m_par ^= q_c[k];
                        if (q_m[k] && m_idx < 0) m_idx = k;
                    end
                    if (m_idx < 0) m_idx = 0;
                    m_hold = 1;
                    q_m.delete();
                    q_c.delete();
                end
            end
            if (STICKY) begin
                if (m_pulse)  m_sticky = 1;
                else if (cs)  m_sticky = 0;
            end

            cyc();
            chk("rnd_out_valid", out_valid, int'(m_hold));
            chk("rnd_pulse", err_pulse, int'(m_pulse));
            chk("rnd_sticky", sticky_err, int'(m_sticky));
            chk("rnd_err_cnt", out_err_cnt, m_cnt);
            chk("rnd_first_idx", out_first_idx, m_idx);
            chk("rnd_parity", out_parity, m_par);
            chk("rnd_out_err", out_err, int'(m_cnt != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
